// File: rtl/fg_fetch_responder_pkg.sv
// Shared types and constants for the foreground fetch responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fg_fetch_responder_pkg;

   localparam int PIXEL_SIZE  = 16;   // RGB565
   localparam int PRECISION   = 11;   // unsigned coord bits; coords carry one extra sign bit
   localparam int FG_WIDTH    = 800;
   localparam int FG_HEIGHT   = 600;
   localparam int ADDR_WIDTH  = 19;
   localparam int SRAM_RD_LAT = 1;
   localparam int FETCH_DELAY = 3;

   typedef logic signed [PRECISION:0] coord_t;
   typedef logic [ADDR_WIDTH-1:0]     addr_t;
   typedef logic [PIXEL_SIZE-1:0]     pixel_t;

   // Per-request tag carried alongside the SRAM read.
   typedef struct packed {
      logic valid;
      logic skip;
   } tag_t;

   // S0 pipeline register contents.
   typedef struct packed {
      logic  valid;
      logic  skip;
      addr_t addr;
   } s0_t;

   localparam coord_t FG_W_C = coord_t'(FG_WIDTH);
   localparam coord_t FG_H_C = coord_t'(FG_HEIGHT);

   // Signed compare over the full coordinate width so negative coords skip.
   function automatic logic in_frame(input coord_t x, input coord_t y);
      return (x >= 0) && (x < FG_W_C) && (y >= 0) && (y < FG_H_C);
   endfunction

   // Row-major word address. Only meaningful when in_frame() holds; the
   // multiply is by a constant so it reduces to shifts and adds.
   function automatic addr_t pix_addr(input coord_t x, input coord_t y);
      return addr_t'(y) * addr_t'(FG_WIDTH) + addr_t'(x);
   endfunction

endpackage

// File: rtl/fg_fetch_delay_line.sv
// Fixed-depth shift register carrying request tags {valid,skip} beside the SRAM read.
// Latency: DEPTH cycles.  Backpressure: none, advances every cycle.
// Ports: clk, rst (sync active-high), din (tag in), dout (tag DEPTH cycles later).
module fg_fetch_delay_line
   import fg_fetch_responder_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t din,
   output tag_t dout
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("fg_fetch_delay_line: DEPTH must be >= 1");
   end

   tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fg_fetch_responder.sv
// Foreground fetch responder: maps signed fg coords to SRAM reads, shares the SRAM port with capture writes.
// Latency: every request answered exactly FETCH_DELAY cycles later, in order, 1 request/cycle.
// Backpressure: requests never stall; capture writes wait (wr_ready=0) whenever a read owns the port.
// Ports: clk/rst; req_x/req_y/req_active in; fg_pixel_out/skip/ready out; ctrl_fg_freeze;
//        wr_valid/wr_addr/wr_data in, wr_ready out; sram_addr/re/we/wdata out, sram_rdata in.
module fg_fetch_responder
   import fg_fetch_responder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [PRECISION:0] req_x,
   input  logic signed [PRECISION:0] req_y,
   input  logic                  req_active,
   output logic [PIXEL_SIZE-1:0] fg_pixel_out,
   output logic                  fg_pixel_skip,
   output logic                  fg_pixel_ready,
   input  logic                  ctrl_fg_freeze,
   input  logic                  wr_valid,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [PIXEL_SIZE-1:0] wr_data,
   output logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_re,
   output logic                  sram_we,
   output logic [PIXEL_SIZE-1:0] sram_wdata,
   input  logic [PIXEL_SIZE-1:0] sram_rdata
);

   // S0 + SRAM_RD_LAT tag stages + output register must add up to the fetch delay.
   if (FETCH_DELAY != SRAM_RD_LAT + 2) begin : g_bad_delay
      $error("fg_fetch_responder: FETCH_DELAY must equal SRAM_RD_LAT + 2");
   end

   s0_t  s0;
   tag_t tag_d;
   logic read_slot;
   logic write_slot;

   // S0: range check and address generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0 <= '0;
      end else begin
         s0.valid <= req_active;
         s0.skip  <= !in_frame(coord_t'(req_x), coord_t'(req_y));
         s0.addr  <= pix_addr(coord_t'(req_x), coord_t'(req_y));
      end
   end

   // S1: reads own the port; any other cycle is a write slot. While frozen
   // the write is still handshaken so the capture side drains, but dropped.
   // rst forces every port output low, including wr_ready.
   assign read_slot  = !rst && s0.valid && !s0.skip;
   assign write_slot = !rst && !read_slot && wr_valid && !ctrl_fg_freeze;

   assign wr_ready   = !rst && !read_slot;
   assign sram_re    = read_slot;
   assign sram_we    = write_slot;
   assign sram_addr  = read_slot  ? s0.addr :
                       write_slot ? wr_addr : '0;
   assign sram_wdata = write_slot ? wr_data : '0;

   // Tags ride alongside the SRAM read so they line up with sram_rdata.
   fg_fetch_delay_line #(
      .DEPTH (SRAM_RD_LAT)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ('{valid: s0.valid, skip: s0.skip}),
      .dout (tag_d)
   );

   // Output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         fg_pixel_ready <= 1'b0;
         fg_pixel_skip  <= 1'b0;
         fg_pixel_out   <= '0;
      end else begin
         fg_pixel_ready <= tag_d.valid;
         fg_pixel_skip  <= tag_d.valid && tag_d.skip;
         fg_pixel_out   <= (tag_d.valid && !tag_d.skip) ? sram_rdata : '0;
      end
   end

endmodule

// File: tb/tb_fg_fetch_responder.sv
// Directed bench for fg_fetch_responder with a 1-cycle-latency SRAM model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fg_fetch_responder;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [11:0] req_x, req_y;
   logic               req_active;
   logic [15:0]        fg_pixel_out;
   logic               fg_pixel_skip, fg_pixel_ready;
   logic               ctrl_fg_freeze;
   logic               wr_valid;
   logic [18:0]        wr_addr;
   logic [15:0]        wr_data;
   logic               wr_ready;
   logic [18:0]        sram_addr;
   logic               sram_re, sram_we;
   logic [15:0]        sram_wdata;
   logic [15:0]        sram_rdata = 16'h0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fg_fetch_responder dut (
      .clk            (clk),
      .rst            (rst),
      .req_x          (req_x),
      .req_y          (req_y),
      .req_active     (req_active),
      .fg_pixel_out   (fg_pixel_out),
      .fg_pixel_skip  (fg_pixel_skip),
      .fg_pixel_ready (fg_pixel_ready),
      .ctrl_fg_freeze (ctrl_fg_freeze),
      .wr_valid       (wr_valid),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_ready       (wr_ready),
      .sram_addr      (sram_addr),
      .sram_re        (sram_re),
      .sram_we        (sram_we),
      .sram_wdata     (sram_wdata),
      .sram_rdata     (sram_rdata)
   );

   // SRAM contents: address 4010 holds magenta, everything else a pattern.
   function automatic logic [15:0] mem_val(input logic [18:0] a);
      return (a == 19'd4010) ? 16'hF81F : (a[15:0] ^ 16'h5A5A);
   endfunction

   always @(posedge clk) begin
      if (sram_re) sram_rdata <= mem_val(sram_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request: S1 port check at T+1, nothing at T+2, response at T+3.
   task automatic single(input int x, input int y, input logic hit,
                         input logic [18:0] exp_addr, input logic [15:0] exp_out);
      req_x = 12'(x); req_y = 12'(y); req_active = 1'b1;
      tick();
      req_active = 1'b0;
      @(negedge clk);
      chk("s1_re", 32'(sram_re), 32'(hit));
      if (hit) chk("s1_addr", 32'(sram_addr), 32'(exp_addr));
      tick();
      @(negedge clk);
      chk("t2_ready", 32'(fg_pixel_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("t3_ready", 32'(fg_pixel_ready), 32'd1);
      chk("t3_skip",  32'(fg_pixel_skip),  32'(!hit));
      chk("t3_out",   32'(fg_pixel_out),   32'(exp_out));
      tick();
   endtask

   initial begin
      rst = 1'b1; req_active = 1'b1; req_x = 12'sd10; req_y = 12'sd5;
      ctrl_fg_freeze = 1'b0; wr_valid = 1'b1; wr_addr = 19'h12345; wr_data = 16'hBEEF;
      repeat (3) tick();

      // Reset state, with a request and a write pending.
      @(negedge clk);
      chk("rst_ready",    32'(fg_pixel_ready), 32'd0);
      chk("rst_skip",     32'(fg_pixel_skip),  32'd0);
      chk("rst_out",      32'(fg_pixel_out),   32'd0);
      chk("rst_wr_ready", 32'(wr_ready),       32'd0);
      chk("rst_we",       32'(sram_we),        32'd0);
      chk("rst_re",       32'(sram_re),        32'd0);
      tick();
      rst = 1'b0; req_active = 1'b0; wr_valid = 1'b0;

      // Requests made during reset must never respond.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_ready", 32'(fg_pixel_ready), 32'd0);
         tick();
      end

      single(10, 5, 1'b1, 19'd4010, 16'hF81F);
      single(-1, 0, 1'b0, 19'd0, 16'h0);
      single(800, 0, 1'b0, 19'd0, 16'h0);
      single(0, 600, 1'b0, 19'd0, 16'h0);
      single(0, -1, 1'b0, 19'd0, 16'h0);
      single(799, 599, 1'b1, 19'd479999, mem_val(19'd479999));

      // Full last row back to back.
      for (int c = 0; c <= 803; c++) begin
         req_active = (c < 800);
         req_x = 12'((c < 800) ? c : 0);
         req_y = 12'sd599;
         @(negedge clk);
         if (c >= 1 && c <= 800) begin
            chk("row_re",   32'(sram_re),   32'd1);
            chk("row_addr", 32'(sram_addr), 32'(479200 + c - 1));
         end
         if (c >= 3 && c <= 802) begin
            chk("row_ready", 32'(fg_pixel_ready), 32'd1);
            chk("row_out",   32'(fg_pixel_out),   32'(mem_val(19'(479200 + c - 3))));
         end else begin
            chk("row_idle", 32'(fg_pixel_ready), 32'd0);
         end
         tick();
      end
      req_active = 1'b0;

      // Write held off by continuous reads, lands on the first free slot.
      for (int c = 0; c <= 6; c++) begin
         req_active = (c < 5);
         req_x = 12'(c); req_y = 12'sd1;
         wr_valid = (c >= 1);
         @(negedge clk);
         if (c >= 1 && c <= 5) begin
            chk("wr_blocked_rdy", 32'(wr_ready), 32'd0);
            chk("wr_blocked_we",  32'(sram_we),  32'd0);
         end
         if (c == 6) begin
            chk("wr_go_rdy",   32'(wr_ready),   32'd1);
            chk("wr_go_we",    32'(sram_we),    32'd1);
            chk("wr_go_addr",  32'(sram_addr),  32'h12345);
            chk("wr_go_wdata", 32'(sram_wdata), 32'hBEEF);
         end
         tick();
      end

      // A skipped request leaves its slot free for a write.
      req_x = 12'sd800; req_y = 12'sd0; req_active = 1'b1;
      tick();
      req_active = 1'b0;
      @(negedge clk);
      chk("skip_slot_rdy", 32'(wr_ready), 32'd1);
      chk("skip_slot_we",  32'(sram_we),  32'd1);
      tick();
      tick();

      // Frozen: writes drained but dropped; a read still works.
      ctrl_fg_freeze = 1'b1;
      for (int c = 0; c < 5; c++) begin
         req_active = (c == 0);
         req_x = 12'sd2; req_y = 12'sd0;
         @(negedge clk);
         chk("frz_we",  32'(sram_we),  32'd0);
         chk("frz_rdy", 32'(wr_ready), (c == 1) ? 32'd0 : 32'd1);
         if (c == 3) begin
            chk("frz_read_ready", 32'(fg_pixel_ready), 32'd1);
            chk("frz_read_out",   32'(fg_pixel_out),   32'h5A58);
         end
         tick();
      end
      ctrl_fg_freeze = 1'b0; wr_valid = 1'b0;
      tick();

      // Reset pulse one cycle after request (3,3) kills it.
      req_x = 12'sd3; req_y = 12'sd3; req_active = 1'b1;
      tick();
      req_active = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("midrst_re", 32'(sram_re), 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_active = (c == 0);
         @(negedge clk);
         if (c == 1) chk("after_rst_addr", 32'(sram_addr), 32'd2403);
         if (c < 3) begin
            chk("killed_ready", 32'(fg_pixel_ready), 32'd0);
         end else begin
            chk("after_rst_ready", 32'(fg_pixel_ready), 32'd1);
            chk("after_rst_skip",  32'(fg_pixel_skip),  32'd0);
            chk("after_rst_out",   32'(fg_pixel_out),   32'h5339);
         end
         tick();
      end
      req_active = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
